pe_stream_loader: RTL and testbench

//  Transmit side of the PE write interface: fetches filter and IFM words from a

---
 rtl/pe_stream_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_pe_stream_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pe_stream_loader.sv
// pe_stream_loader: reads filter and IFM words from a 1-cycle-latency SRAM
// and streams them into a pe over the w_en/ready write interface.
// IFM words carry a 2-bit row tag: 10 first, 00 middle, 01 last, 11 single.
// Optional feature macro PSUM_LOAD_EN adds a partial-sum phase after IFM.
module pe_stream_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] fil_base,
    input  logic [LEN_WIDTH-1:0]  fil_len,
    input  logic [ADDR_WIDTH-1:0] ifm_base,
    input  logic [LEN_WIDTH-1:0]  ifm_len,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  w_en_fil,
    output logic [DATA_WIDTH-1:0] data_in_fil,
    input  logic                  ready_fil,
    output logic                  w_en_ifm,
    output logic [DATA_WIDTH+1:0] data_in_ifm,
    input  logic                  ready_ifm,
    output logic                  busy,
    output logic                  done
`ifdef PSUM_LOAD_EN
    ,
    input  logic [ADDR_WIDTH-1:0] psum_base,
    input  logic [LEN_WIDTH-1:0]  psum_len,
    output logic                  w_en_psum,
    output logic [DATA_WIDTH-1:0] data_in_psum,
    input  logic                  ready_psum
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIL_RD,
        ST_FIL_TX,
        ST_IFM_RD,
        ST_IFM_TX,
`ifdef PSUM_LOAD_EN
        ST_PSUM_RD,
        ST_PSUM_TX,
`endif
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] fil_base_q, fil_base_d, ifm_base_q, ifm_base_d;
    logic [LEN_WIDTH-1:0]  fil_len_q, fil_len_d, ifm_len_q, ifm_len_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  first_q, first_d;
`ifdef PSUM_LOAD_EN
    logic [ADDR_WIDTH-1:0] psum_base_q, psum_base_d;
    logic [LEN_WIDTH-1:0]  psum_len_q, psum_len_d;
`endif

    logic [ADDR_WIDTH-1:0] cur_base;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic                  cur_ready, is_rd, last;
    state_t                phase_rd, phase_after, after_fil, after_ifm, launch;
    logic [DATA_WIDTH-1:0] word;
    logic [1:0]            tag;

    // Decode which phase is active and where each phase hands over next
    always_comb begin
        cur_base  = '0;
        cur_len   = '0;
        cur_ready = 1'b0;
        is_rd     = 1'b0;
        phase_rd  = ST_IDLE;
        after_ifm = ST_DONE;
`ifdef PSUM_LOAD_EN
        if (psum_len_q != '0) after_ifm = ST_PSUM_RD;
`endif
        after_fil   = (ifm_len_q != '0) ? ST_IFM_RD : after_ifm;
        phase_after = ST_DONE;
        case (state_q)
            ST_FIL_RD, ST_FIL_TX: begin
                cur_base    = fil_base_q;
                cur_len     = fil_len_q;
                cur_ready   = ready_fil;
                is_rd       = (state_q == ST_FIL_RD);
                phase_rd    = ST_FIL_RD;
                phase_after = after_fil;
            end
            ST_IFM_RD, ST_IFM_TX: begin
                cur_base    = ifm_base_q;
                cur_len     = ifm_len_q;
                cur_ready   = ready_ifm;
                is_rd       = (state_q == ST_IFM_RD);
                phase_rd    = ST_IFM_RD;
                phase_after = after_ifm;
            end
`ifdef PSUM_LOAD_EN
            ST_PSUM_RD, ST_PSUM_TX: begin
                cur_base    = psum_base_q;
                cur_len     = psum_len_q;
                cur_ready   = ready_psum;
                is_rd       = (state_q == ST_PSUM_RD);
                phase_rd    = ST_PSUM_RD;
                phase_after = ST_DONE;
            end
`endif
            default: ;
        endcase
        last = (cnt_q == cur_len - LEN_WIDTH'(1));

        // First non-empty phase, judged from the live inputs on the start cycle
        launch = ST_DONE;
`ifdef PSUM_LOAD_EN
        if (psum_len != '0) launch = ST_PSUM_RD;
`endif
        if (ifm_len != '0) launch = ST_IFM_RD;
        if (fil_len != '0) launch = ST_FIL_RD;
    end

    // Next-state, counter and holding-register update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fil_base_d = fil_base_q;
        fil_len_d  = fil_len_q;
        ifm_base_d = ifm_base_q;
        ifm_len_d  = ifm_len_q;
`ifdef PSUM_LOAD_EN
        psum_base_d = psum_base_q;
        psum_len_d  = psum_len_q;
`endif
        hold_d  = hold_q;
        first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fil_base_d = fil_base;
                    fil_len_d  = fil_len;
                    ifm_base_d = ifm_base;
                    ifm_len_d  = ifm_len;
`ifdef PSUM_LOAD_EN
                    psum_base_d = psum_base;
                    psum_len_d  = psum_len;
`endif
                    cnt_d   = '0;
                    state_d = launch;
                end
            end
            ST_FIL_RD: begin state_d = ST_FIL_TX; first_d = 1'b1; end
            ST_IFM_RD: begin state_d = ST_IFM_TX; first_d = 1'b1; end
`ifdef PSUM_LOAD_EN
            ST_PSUM_RD: begin state_d = ST_PSUM_TX; first_d = 1'b1; end
            ST_PSUM_TX,
`endif
            ST_FIL_TX, ST_IFM_TX: begin
                // SRAM data is only valid on the first TX cycle; keep a copy for stalls
                if (first_q) hold_d = mem_rdata;
                if (cur_ready) begin
                    if (last) begin
                        cnt_d   = '0;
                        state_d = phase_after;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = phase_rd;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: first TX cycle forwards SRAM data, later cycles the held copy
    always_comb begin
        word = first_q ? mem_rdata : hold_q;
        if (cnt_q == '0 && cur_len == LEN_WIDTH'(1)) tag = 2'b11;
        else if (cnt_q == '0)                        tag = 2'b10;
        else if (last)                               tag = 2'b01;
        else                                         tag = 2'b00;
        mem_ren     = is_rd;
        mem_addr    = is_rd ? cur_base + ADDR_WIDTH'(cnt_q) : '0;
        w_en_fil    = (state_q == ST_FIL_TX);
        data_in_fil = w_en_fil ? word : '0;
        w_en_ifm    = (state_q == ST_IFM_TX);
        data_in_ifm = w_en_ifm ? {tag, word} : '0;
`ifdef PSUM_LOAD_EN
        w_en_psum    = (state_q == ST_PSUM_TX);
        data_in_psum = w_en_psum ? word : '0;
`endif
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fil_base_q <= '0;
            fil_len_q  <= '0;
            ifm_base_q <= '0;
            ifm_len_q  <= '0;
`ifdef PSUM_LOAD_EN
            psum_base_q <= '0;
            psum_len_q  <= '0;
`endif
            hold_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fil_base_q <= fil_base_d;
            fil_len_q  <= fil_len_d;
            ifm_base_q <= ifm_base_d;
            ifm_len_q  <= ifm_len_d;
`ifdef PSUM_LOAD_EN
            psum_base_q <= psum_base_d;
            psum_len_q  <= psum_len_d;
`endif
            hold_q  <= hold_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_pe_stream_loader.sv
// Bench for pe_stream_loader: table of transfer jobs, SRAM model, and a
// scoreboard of expected addresses and words filled when each job starts.
module tb_pe_stream_loader;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [AW-1:0] fil_base, ifm_base, mem_addr;
    logic [LW-1:0] fil_len, ifm_len;
    logic          mem_ren, w_en_fil, ready_fil, w_en_ifm, ready_ifm, busy, done;
    logic [DW-1:0] mem_rdata, data_in_fil;
    logic [DW+1:0] data_in_ifm;

    always #5 clk = ~clk;

    pe_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .fil_base(fil_base), .fil_len(fil_len),
        .ifm_base(ifm_base), .ifm_len(ifm_len),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .w_en_fil(w_en_fil), .data_in_fil(data_in_fil), .ready_fil(ready_fil),
        .w_en_ifm(w_en_ifm), .data_in_ifm(data_in_ifm), .ready_ifm(ready_ifm),
        .busy(busy), .done(done)
    );

    // SRAM model: data one cycle after mem_ren, garbage otherwise
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_addr] : DW'($urandom);

    typedef struct {
        logic [AW-1:0] fb;
        int            fl;
        logic [AW-1:0] ib;
        int            il;
        int            stall_idx;
        int            stall_cyc;
        int            exp_busy;
        bit            poke_start;
        int            rst_at;
    } vec_t;

    typedef struct {
        bit            ifm;
        logic [DW+1:0] d;
    } xfer_t;

    xfer_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    vec_t          vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {mem_ren, mem_addr, w_en_fil, data_in_fil, w_en_ifm, data_in_ifm, busy, done};
    endfunction

    task automatic run_vec(input vec_t v);
        int            busy_cyc = 0, ifm_x = 0, stall_n = 0, cyc = 0, last_x = 0;
        bit            fin = 0, poked = 0;
        logic [DW+1:0] held = '0;
        logic [AW-1:0] a;
        logic [1:0]    tg;
        xfer_t         e;
        for (int i = 0; i < v.fl; i++) begin
            a = v.fb + AW'(i);
            addr_q.push_back(a);
            e.ifm = 1'b0; e.d = {2'b00, mem[a]};
            exp_q.push_back(e);
        end
        for (int i = 0; i < v.il; i++) begin
            a  = v.ib + AW'(i);
            tg = (v.il == 1) ? 2'b11 : (i == 0) ? 2'b10 : (i == v.il - 1) ? 2'b01 : 2'b00;
            addr_q.push_back(a);
            e.ifm = 1'b1; e.d = {tg, mem[a]};
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b1; fil_base = v.fb; fil_len = LW'(v.fl); ifm_base = v.ib; ifm_len = LW'(v.il);
        @(negedge clk);
        start = 1'b0; fil_base = AW'($urandom); ifm_base = AW'($urandom);
        fil_len = LW'($urandom); ifm_len = LW'($urandom);
        while (!fin && cyc < 400) begin
            cyc++;
            start = 1'b0;
            if (v.rst_at >= 0 && w_en_ifm && ifm_x == v.rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("reset_mid_outputs", all_outs(), 64'd0);
                rst_n = 1'b1;
                exp_q.delete();
                addr_q.delete();
                return;
            end
            if (w_en_fil && w_en_ifm) chk("w_en_exclusive", 1, 0);
            if (mem_ren) begin
                if (addr_q.size() == 0) chk("extra_mem_ren", {56'd0, mem_addr}, 64'hFFFF);
                else chk("mem_addr", {56'd0, mem_addr}, {56'd0, addr_q.pop_front()});
            end
            if (busy) busy_cyc++;
            ready_fil = 1'b1;
            ready_ifm = 1'b1;
            if (w_en_ifm && ifm_x == v.stall_idx) begin
                if (stall_n == 0) held = data_in_ifm;
                else chk("stall_hold", {46'd0, data_in_ifm}, {46'd0, held});
                if (stall_n < v.stall_cyc) ready_ifm = 1'b0;
                stall_n++;
            end
            if ((w_en_fil && ready_fil) || (w_en_ifm && ready_ifm)) begin
                if (exp_q.size() == 0) chk("extra_transfer", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    if (w_en_fil) chk("fil_word", {45'd0, 1'b0, 2'b00, data_in_fil}, {45'd0, e.ifm, e.d});
                    else          chk("ifm_word", {45'd0, 1'b1, data_in_ifm}, {45'd0, e.ifm, e.d});
                end
                if (w_en_ifm) ifm_x++;
                last_x = cyc;
            end
            if (v.poke_start && w_en_ifm && !poked) begin
                start = 1'b1; fil_base = 8'h11; fil_len = 5'd4; ifm_base = 8'h22; ifm_len = 5'd3;
                poked = 1;
            end
            if (done) begin
                chk("done_latency", 64'(cyc - last_x), 64'd1);
                chk("queues_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
                fin = 1;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: done not seen within 400 cycles");
            exp_q.delete();
            addr_q.delete();
            return;
        end
        chk("busy_cycles", 64'(busy_cyc), 64'(v.exp_busy));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_after_done", {62'd0, busy, done | mem_ren}, 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        //         fb     fl  ib     il  stall  cyc busy poke rst
        vecs[0] = '{8'h0A, 10, 8'h28, 12, -1, 0,  45, 0, -1};
        vecs[1] = '{8'h80,  3, 8'h90,  8,  5, 7,  30, 0, -1};
        vecs[2] = '{8'h00,  0, 8'h20,  1, -1, 0,   3, 0, -1};
        vecs[3] = '{8'h00,  0, 8'h00,  0, -1, 0,   1, 0, -1};
        vecs[4] = '{8'h05,  2, 8'h60,  6, -1, 0,  17, 1, -1};
        vecs[5] = '{8'h30,  4, 8'h70, 10, -1, 0,  -1, 0,  3};
        vecs[6] = '{8'h31,  2, 8'h70,  5, -1, 0,  15, 0, -1};
        vecs[7] = '{8'hFF,  2, 8'hFE,  4, -1, 0,  13, 0, -1};
        vecs[8] = '{8'hF0, 31, 8'h00, 31, -1, 0, 125, 0, -1};

        rst_n = 1'b0; start = 1'b0; fil_base = '0; fil_len = '0; ifm_base = '0; ifm_len = '0;
        ready_fil = 1'b1; ready_ifm = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", all_outs(), 64'd0);

        for (int n = 0; n < 9; n++) run_vec(vecs[n]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
